// File: rtl/seq_matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared types and helpers for the sequential matrix multiplier.
//   state_e   : controller states (LOAD, MAC, EMIT)
//   acc_width : result width that cannot overflow for a K-term dot product
//   idx       : row-major flat index of element [r][c] in a matrix of 'cols'
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Products are 2*DW wide; summing K of them needs clog2(K) extra bits.
    function automatic int acc_width(input int dw, input int k);
        return (k <= 1) ? (2 * dw) : (2 * dw + $clog2(k));
    endfunction

    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/seq_matmul_if.sv
// -----------------------------------------------------------------------------
// seq_matmul_if
// Element-stream input and result-stream output of the matrix multiplier.
//   in_valid/in_ready/in_data            : A then B, row-major, one element/beat
//   out_valid/out_ready/out_data/out_last: C row-major, out_last on C[M-1][N-1]
// Modports: slave = the multiplier, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface seq_matmul_if #(
    parameter int DW = 4,
    parameter int OW = 9
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/seq_matmul_mac.sv
// -----------------------------------------------------------------------------
// matmul_mac
// Single multiply-accumulate unit.
//   clk, rst_n : clock, asynchronous active-low reset (acc -> 0)
//   a, b       : DW-bit operands (signed when SIGNED=1)
//   clr        : synchronous clear of the accumulator (wins over en)
//   en         : add a*b into the accumulator this cycle
//   acc        : OW-bit registered accumulator
// -----------------------------------------------------------------------------
module matmul_mac #(
    parameter int DW     = 4,
    parameter int OW     = 9,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          clr,
    input  logic          en,
    output logic [OW-1:0] acc
);

    logic          a_fill_s;
    logic          b_fill_s;
    logic [OW-1:0] a_ext_s;
    logic [OW-1:0] b_ext_s;
    logic [OW-1:0] prod_s;
    logic [OW-1:0] acc_q;

    assign a_fill_s = (SIGNED != 0) ? a[DW-1] : 1'b0;
    assign b_fill_s = (SIGNED != 0) ? b[DW-1] : 1'b0;
    assign a_ext_s  = {{(OW-DW){a_fill_s}}, a};
    assign b_ext_s  = {{(OW-DW){b_fill_s}}, b};

    // Multiplying the already-extended operands and keeping the low OW bits
    // gives the exact two's-complement (or unsigned) product, since the true
    // product always fits in OW bits.
    assign prod_s = a_ext_s * b_ext_s;

    // Accumulator register: clear has priority over accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + prod_s;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/seq_matmul.sv
// -----------------------------------------------------------------------------
// seq_matmul
// Sequential C = A*B using one MAC. A (M x K) then B (K x N) arrive row-major
// on the input stream; C (M x N) leaves row-major with backpressure.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seq_matmul_if.slave (input stream, output stream)
//   busy       : high everywhere except idle LOAD with no element taken
// Each result takes K MAC cycles plus one cycle to present it.
// -----------------------------------------------------------------------------
module seq_matmul
    import matmul_pkg::*;
#(
    parameter int M      = 4,
    parameter int K      = 2,
    parameter int N      = 2,
    parameter int DW     = 4,
    parameter int SIGNED = 0,
    parameter int OW     = acc_width(DW, K)
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_matmul_if.slave bus,
    output logic        busy
);

    localparam int NA  = M * K;
    localparam int NB  = K * N;
    localparam int NL  = NA + NB;
    localparam int CW  = $clog2(NL);
    localparam int AAW = (NA > 1) ? $clog2(NA) : 1;
    localparam int BAW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW  = (M > 1) ? $clog2(M) : 1;
    localparam int JW  = (N > 1) ? $clog2(N) : 1;
    localparam int KW  = (K > 1) ? $clog2(K) : 1;

    state_e         state_q;
    logic [CW-1:0]  load_cnt_q;
    logic [IW-1:0]  i_q;
    logic [JW-1:0]  j_q;
    logic [KW-1:0]  k_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic           busy_q;

    logic [DW-1:0]  a_mem_q [NA];
    logic [DW-1:0]  b_mem_q [NB];

    logic           in_hs_s;
    logic           out_hs_s;
    logic           load_last_s;
    logic           a_sel_s;
    logic           i_last_s;
    logic           j_last_s;
    logic           k_last_s;
    logic [AAW-1:0] a_wr_addr_s;
    logic [BAW-1:0] b_wr_addr_s;
    logic [AAW-1:0] a_rd_addr_s;
    logic [BAW-1:0] b_rd_addr_s;
    logic           mac_clr_s;
    logic           mac_en_s;
    logic [OW-1:0]  acc_s;

    // in_ready is only high in LOAD, so in_valid elsewhere is never consumed.
    assign in_hs_s     = bus.in_valid & in_ready_q;
    assign out_hs_s    = out_valid_q & bus.out_ready;
    assign load_last_s = (load_cnt_q == CW'(NL - 1));
    assign a_sel_s     = (load_cnt_q < CW'(NA));
    assign i_last_s    = (i_q == IW'(M - 1));
    assign j_last_s    = (j_q == JW'(N - 1));
    assign k_last_s    = (k_q == KW'(K - 1));

    assign a_wr_addr_s = AAW'(load_cnt_q);
    assign b_wr_addr_s = BAW'(load_cnt_q - CW'(NA));
    assign a_rd_addr_s = AAW'(idx(int'(i_q), int'(k_q), K));
    assign b_rd_addr_s = BAW'(idx(int'(k_q), int'(j_q), N));

    // Element storage write port; contents are fully rewritten by every load
    always_ff @(posedge clk) begin
        if (in_hs_s) begin
            if (a_sel_s) begin
                a_mem_q[a_wr_addr_s] <= bus.in_data;
            end else begin
                b_mem_q[b_wr_addr_s] <= bus.in_data;
            end
        end
    end

    // MAC control: clear when a new dot product starts, accumulate in MAC
    always_comb begin
        mac_en_s  = 1'b0;
        mac_clr_s = 1'b0;
        case (state_q)
            LOAD: begin
                mac_en_s  = 1'b0;
                mac_clr_s = in_hs_s & load_last_s;
            end
            MAC: begin
                mac_en_s  = 1'b1;
                mac_clr_s = 1'b0;
            end
            EMIT: begin
                mac_en_s  = 1'b0;
                mac_clr_s = out_hs_s;
            end
            default: begin
                mac_en_s  = 1'b0;
                mac_clr_s = 1'b0;
            end
        endcase
    end

    matmul_mac #(
        .DW     (DW),
        .OW     (OW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_mem_q[a_rd_addr_s]),
        .b     (b_mem_q[b_rd_addr_s]),
        .clr   (mac_clr_s),
        .en    (mac_en_s),
        .acc   (acc_s)
    );

    // Controller FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            load_cnt_q  <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_hs_s) begin
                        busy_q <= 1'b1;
                        if (load_last_s) begin
                            state_q    <= MAC;
                            in_ready_q <= 1'b0;
                            load_cnt_q <= '0;
                            i_q        <= '0;
                            j_q        <= '0;
                            k_q        <= '0;
                        end else begin
                            load_cnt_q <= load_cnt_q + CW'(1);
                        end
                    end
                end
                MAC: begin
                    if (k_last_s) begin
                        state_q     <= EMIT;
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= i_last_s & j_last_s;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                EMIT: begin
                    if (out_hs_s) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            i_q        <= '0;
                            j_q        <= '0;
                        end else begin
                            state_q <= MAC;
                            if (j_last_s) begin
                                j_q <= '0;
                                i_q <= i_q + IW'(1);
                            end else begin
                                j_q <= j_q + JW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= LOAD;
                    load_cnt_q  <= '0;
                    i_q         <= '0;
                    j_q         <= '0;
                    k_q         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // out_data is the accumulator itself; it is held while EMIT stalls.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_s;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_seq_matmul.sv
// -----------------------------------------------------------------------------
// tb_seq_matmul
// Three builds: default unsigned, default signed, and unsigned M=3 K=4 N=5 DW=8.
// Table vectors cover the 4x2*2x2 cases; hand sequences cover backpressure,
// random gaps/ready, and reset in the middle of a computation.
// -----------------------------------------------------------------------------
module tb_seq_matmul;

    logic       clk = 1'b0;
    logic       rst_n;
    int         sel;
    logic       iv;
    logic       ordy;
    logic [7:0] id;

    int nvec  = 0;
    int nfail = 0;

    int stream [64];
    int exp_q  [64];

    always #5 clk = ~clk;

    seq_matmul_if #(.DW(4), .OW(9))  if0 ();
    seq_matmul_if #(.DW(4), .OW(9))  if1 ();
    seq_matmul_if #(.DW(8), .OW(18)) if2 ();

    logic bz0, bz1, bz2;

    assign if0.in_valid  = (sel == 0) ? iv : 1'b0;
    assign if1.in_valid  = (sel == 1) ? iv : 1'b0;
    assign if2.in_valid  = (sel == 2) ? iv : 1'b0;
    assign if0.out_ready = (sel == 0) ? ordy : 1'b0;
    assign if1.out_ready = (sel == 1) ? ordy : 1'b0;
    assign if2.out_ready = (sel == 2) ? ordy : 1'b0;
    assign if0.in_data   = id[3:0];
    assign if1.in_data   = id[3:0];
    assign if2.in_data   = id;

    seq_matmul #(.M(4), .K(2), .N(2), .DW(4), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(bz0));
    seq_matmul #(.M(4), .K(2), .N(2), .DW(4), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(bz1));
    seq_matmul #(.M(3), .K(4), .N(5), .DW(8), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(bz2));

    logic        cur_ov, cur_ir, cur_ol, cur_bz;
    logic [31:0] cur_od;

    // Observation mux onto the build currently under test
    always_comb begin
        case (sel)
            0: begin
                cur_ov = if0.out_valid; cur_ir = if0.in_ready;
                cur_ol = if0.out_last;  cur_bz = bz0;
                cur_od = {23'd0, if0.out_data};
            end
            1: begin
                cur_ov = if1.out_valid; cur_ir = if1.in_ready;
                cur_ol = if1.out_last;  cur_bz = bz1;
                cur_od = {23'd0, if1.out_data};
            end
            default: begin
                cur_ov = if2.out_valid; cur_ir = if2.in_ready;
                cur_ol = if2.out_last;  cur_bz = bz2;
                cur_od = {14'd0, if2.out_data};
            end
        endcase
    end

    typedef struct packed {
        logic [1:0]      sel;
        logic [0:7][3:0] a;
        logic [0:3][3:0] b;
        logic [0:7][8:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic set_vec(input int v);
        for (int e = 0; e < 8; e++) stream[e]     = int'(vecs[v].a[e]);
        for (int e = 0; e < 4; e++) stream[8 + e] = int'(vecs[v].b[e]);
        for (int r = 0; r < 8; r++) exp_q[r]      = int'(vecs[v].exp[r]);
    endtask

    // Streams n elements; gap_pct>0 inserts random idle cycles.
    task automatic load_stream(input string tag, input int n, input int gap_pct);
        int e = 0;
        int guard = 0;
        while (e < n && guard < 3000) begin
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                iv = 1'b0;
            end else begin
                iv = 1'b1;
                id = 8'(stream[e]);
            end
            if (iv && cur_ir) e++;
            tick();
            guard++;
        end
        iv = 1'b0;
        if (e < n) begin
            nvec++; nfail++;
            $display("FAIL %s_load_timeout: accepted %0d, expected %0d", tag, e, n);
        end
    endtask

    // mode 0: ready high; 1: 5-cycle stall on result 2 with in_valid pulsed;
    // 2: random out_ready. Expects one result every klat+1 cycles of compute.
    task automatic collect(input string tag, input int n, input int mode, input int klat);
        int cnt;
        for (int r = 0; r < n; r++) begin
            if (mode == 1 && r == 2) begin
                iv = 1'b1;
                id = 8'hFF;
            end
            if (mode != 2) ordy = 1'b1;
            cnt = 0;
            while (!cur_ov && cnt < 200) begin
                if (mode == 2) ordy = ($urandom_range(1, 0) != 0);
                if (mode == 1 && r == 2) chk($sformatf("%s_r%0d_inrdy_mac", tag, r), cur_ir, 0);
                tick();
                cnt++;
            end
            if (!cur_ov) begin
                nvec++; nfail++;
                $display("FAIL %s_r%0d_timeout: out_valid=0, expected 1 within 200 cycles", tag, r);
                iv = 1'b0;
                return;
            end
            chk($sformatf("%s_r%0d_gap", tag, r), cnt, klat);
            chk($sformatf("%s_r%0d_data", tag, r), cur_od, exp_q[r]);
            chk($sformatf("%s_r%0d_last", tag, r), cur_ol, (r == n - 1) ? 1 : 0);
            if (r == 0) chk($sformatf("%s_busy", tag), cur_bz, 1);
            if (mode == 1 && r == 2) begin
                ordy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk($sformatf("%s_stall%0d_valid", tag, s), cur_ov, 1);
                    chk($sformatf("%s_stall%0d_data", tag, s), cur_od, exp_q[r]);
                    chk($sformatf("%s_stall%0d_inrdy", tag, s), cur_ir, 0);
                end
                iv = 1'b0;
            end
            if (mode == 2) begin
                cnt = 0;
                while ($urandom_range(2, 0) == 0 && cnt < 20) begin
                    ordy = 1'b0;
                    tick();
                    cnt++;
                    chk($sformatf("%s_r%0d_hold", tag, r), cur_od, exp_q[r]);
                end
            end
            ordy = 1'b1;
            tick();
        end
        ordy = 1'b0;
        chk($sformatf("%s_end_inrdy", tag), cur_ir, 1);
        chk($sformatf("%s_end_valid", tag), cur_ov, 0);
        chk($sformatf("%s_end_busy", tag), cur_bz, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s_inrdy", tag), cur_ir, 1);
        chk($sformatf("%s_valid", tag), cur_ov, 0);
        chk($sformatf("%s_last", tag), cur_ol, 0);
        chk($sformatf("%s_data", tag), cur_od, 0);
        chk($sformatf("%s_busy", tag), cur_bz, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int wa [12];
        int wb [20];
        int cnt;

        vecs[0].sel = 2'd0;
        vecs[0].a   = {4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd3};
        vecs[0].b   = {4'd6, 4'd5, 4'd1, 4'd3};
        vecs[0].exp = {9'd8, 9'd11, 9'd14, 9'd16, 9'd13, 9'd13, 9'd15, 9'd19};
        vecs[1].sel = 2'd0;
        vecs[1].a   = {4'd7, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2, 4'd6};
        vecs[1].b   = {4'd6, 4'd5, 4'd1, 4'd3};
        vecs[1].exp = {9'd44, 9'd41, 9'd14, 9'd16, 9'd13, 9'd13, 9'd18, 9'd28};
        vecs[2].sel = 2'd0;
        vecs[2].a   = {8{4'hF}};
        vecs[2].b   = {4{4'hF}};
        vecs[2].exp = {8{9'd450}};
        vecs[3].sel = 2'd1;
        vecs[3].a   = {8{4'h8}};
        vecs[3].b   = {4{4'h8}};
        vecs[3].exp = {8{9'h080}};          // +128
        vecs[4].sel = 2'd1;
        vecs[4].a   = {8{4'h8}};
        vecs[4].b   = {4{4'h7}};
        vecs[4].exp = {8{9'h190}};          // -112 in 9 bits

        iv = 1'b0; ordy = 1'b0; id = 8'd0; sel = 0; rst_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_reset_vals($sformatf("rst%0d", s));
        end
        sel = 0;
        rst_n = 1'b1;
        tick();

        // Table vectors, back to back with in_valid held and out_ready high
        for (int v = 0; v < 5; v++) begin
            sel = int'(vecs[v].sel);
            #1;
            set_vec(v);
            load_stream($sformatf("v%0d", v), 12, 0);
            collect($sformatf("v%0d", v), 8, 0, 2);
        end

        // Backpressure plus ignored in_valid, then a clean reload
        sel = 0;
        #1;
        set_vec(0);
        load_stream("bp", 12, 0);
        collect("bp", 8, 1, 2);
        set_vec(1);
        load_stream("bp_after", 12, 0);
        collect("bp_after", 8, 0, 2);

        // Wide build with random gaps and random out_ready
        sel = 2;
        #1;
        for (int e = 0; e < 12; e++) wa[e] = (e == 0) ? 255 : int'($urandom_range(255, 0));
        for (int e = 0; e < 20; e++) wb[e] = (e == 0) ? 255 : int'($urandom_range(255, 0));
        for (int e = 0; e < 12; e++) stream[e] = wa[e];
        for (int e = 0; e < 20; e++) stream[12 + e] = wb[e];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 5; j++) begin
                exp_q[i * 5 + j] = 0;
                for (int k = 0; k < 4; k++) exp_q[i * 5 + j] += wa[i * 4 + k] * wb[k * 5 + j];
            end
        end
        load_stream("wide", 32, 40);
        collect("wide", 15, 2, 4);

        // Reset while in MAC
        sel = 0;
        #1;
        set_vec(0);
        load_stream("rmac", 12, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rmac_low");
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("rmac_stale%0d", s), cur_ov, 0);
        end
        set_vec(1);
        load_stream("rmac_fresh", 12, 0);
        collect("rmac_fresh", 8, 0, 2);

        // Reset while stalled in EMIT
        set_vec(0);
        load_stream("remit", 12, 0);
        ordy = 1'b0;
        cnt = 0;
        while (!cur_ov && cnt < 50) begin
            tick();
            cnt++;
        end
        tick();
        tick();
        chk("remit_valid_before", cur_ov, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("remit_low");
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("remit_stale%0d", s), cur_ov, 0);
        end
        set_vec(2);
        load_stream("remit_fresh", 12, 0);
        collect("remit_fresh", 8, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
